mem_sram_port: RTL and testbench

MEM_SRAM_PORT -- requirements
Module: mem_sram_port

---
 rtl/mem_sram_port.sv | 180 ++++++++++++++++++
 tb/tb_mem_sram_port.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_port.sv
// Single-port asynchronous SRAM controller: registers one request from the cache
// controller and sequences SETUP / ACCESS (WAIT+1 cycles) / DONE with registered strobes.
module mem_sram_port #(
    parameter int unsigned WAIT = 2
) (
    input  logic        ph1,
    input  logic        ph2,
    input  logic        reset,
    input  logic [26:0] adr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    input  logic        rwb,
    input  logic        en,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic [26:0] sram_adr,
    output logic [31:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [31:0] sram_dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n
);

    localparam int unsigned ADR_W  = 27;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     byteen_q, byteen_d;
    logic                rwb_q, rwb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic [BE_W-1:0]     be_lanes_c;

    // ph2 exists only to pair with ph1 at the pad ring
    logic unused_ph2;
    assign unused_ph2 = ph2;

    // State, request and registered-output flops
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            adr_q    <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            rwb_q    <= 1'b1;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            be_n_q   <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            byteen_q <= byteen_d;
            rwb_q    <= rwb_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            dq_oe_q  <= dq_oe_d;
            be_n_q   <= be_n_d;
        end
    end

    // Next state, request capture, wait counter and read-data capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        byteen_d = byteen_q;
        rwb_d    = rwb_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    adr_d    = adr;
                    wdata_d  = wdata;
                    byteen_d = byteen;
                    rwb_d    = rwb;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_W'(WAIT);
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (rwb_q) begin
                        rdata_d = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobe decode from the upcoming state so every pad output comes straight from a flop
    always_comb begin
        be_lanes_c = rwb_d ? '0 : ~byteen_d;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        ce_n_d     = 1'b1;
        oe_n_d     = 1'b1;
        we_n_d     = 1'b1;
        dq_oe_d    = 1'b0;
        be_n_d     = '1;
        case (state_d)
            ST_SETUP: begin
                ce_n_d  = 1'b0;
                dq_oe_d = !rwb_d;
                be_n_d  = be_lanes_c;
            end
            ST_ACCESS: begin
                ce_n_d  = 1'b0;
                oe_n_d  = !rwb_d;
                we_n_d  = !(!rwb_d && (byteen_d != '0));
                dq_oe_d = !rwb_d;
                be_n_d  = be_lanes_c;
            end
            ST_DONE: begin
                dq_oe_d = !rwb_d;
                be_n_d  = be_lanes_c;
            end
            default: begin
                be_n_d = '1;
            end
        endcase
    end

    assign rdata      = rdata_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign sram_adr   = adr_q;
    assign sram_dq_o  = wdata_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_be_n  = be_n_q;

endmodule

// File: tb/tb_mem_sram_port.sv
// Bench for mem_sram_port: directed vector table, back-to-back, reset-abort and WAIT=0
// sequences, then random traffic checked against a byte-lane memory model.
module tb_mem_sram_port;

    localparam int unsigned W = 2;

    logic        ph1, ph2, reset;
    logic [26:0] adr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic        rwb, en;
    logic [31:0] rdata;
    logic        done, busy;
    logic [26:0] sram_adr;
    logic [31:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    logic [26:0] w0_adr;
    logic [31:0] w0_wdata;
    logic [3:0]  w0_byteen;
    logic        w0_rwb, w0_en;
    logic [31:0] w0_rdata;
    logic        w0_done, w0_busy;
    logic [26:0] w0_sram_adr;
    logic [31:0] w0_sram_dq_o, w0_sram_dq_i;
    logic        w0_sram_dq_oe, w0_sram_ce_n, w0_sram_oe_n, w0_sram_we_n;
    logic [3:0]  w0_sram_be_n;

    int errors = 0;
    int checks = 0;

    // SRAM array driven only by the DUT strobes
    logic [31:0] mem [0:4095];
    // Reference: pool of 16 words plus last read value
    logic [31:0] ref_mem [0:15];
    logic [31:0] ref_rdata;

    typedef struct {
        logic        rw;
        logic [26:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        int          exp_oe;
        int          exp_we;
        logic [3:0]  exp_ben;
    } vec_t;
    vec_t tbl [8];

    mem_sram_port #(.WAIT(W)) u_dut (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .adr(adr), .wdata(wdata), .byteen(byteen), .rwb(rwb), .en(en),
        .rdata(rdata), .done(done), .busy(busy),
        .sram_adr(sram_adr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    mem_sram_port #(.WAIT(0)) u_w0 (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .adr(w0_adr), .wdata(w0_wdata), .byteen(w0_byteen), .rwb(w0_rwb), .en(w0_en),
        .rdata(w0_rdata), .done(w0_done), .busy(w0_busy),
        .sram_adr(w0_sram_adr), .sram_dq_o(w0_sram_dq_o), .sram_dq_oe(w0_sram_dq_oe),
        .sram_dq_i(w0_sram_dq_i), .sram_ce_n(w0_sram_ce_n), .sram_oe_n(w0_sram_oe_n),
        .sram_we_n(w0_sram_we_n), .sram_be_n(w0_sram_be_n)
    );

    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #1 ph1 = 1'b1;
            #4 ph1 = 1'b0;
            #1 ph2 = 1'b1;
            #3 ph2 = 1'b0;
            #1;
        end
    end

    assign sram_dq_i    = !sram_oe_n ? mem[sram_adr[11:0]] : 32'h0;
    assign w0_sram_dq_i = 32'h5A5A5A5A;

    always @(negedge ph1) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int i = 0; i < 4; i++) begin
                if (!sram_be_n[i]) mem[sram_adr[11:0]][8*i +: 8] <= sram_dq_o[8*i +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    // Starts and ends at the falling ph1 of an IDLE cycle
    task automatic do_op(input string tag, input logic rw, input logic [26:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input bit scramble,
                         input bit hold, input logic [31:0] exp_rd, input int exp_oe,
                         input int exp_we, input logic [3:0] exp_ben);
        int          lat, oe_low, we_low, dqoe_hi;
        bit          overlap;
        logic        ce_s;
        logic [3:0]  ben_s;
        logic [26:0] adr_s;
        logic [31:0] dqo_s;
        lat = 0; oe_low = 0; we_low = 0; dqoe_hi = 0; overlap = 0;
        ce_s = 1'b1; ben_s = '0; adr_s = '0; dqo_s = '0;
        rwb = rw; adr = a; wdata = wd; byteen = be; en = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge ph1); @(negedge ph1);
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (sram_dq_oe) dqoe_hi++;
            if (!sram_oe_n && !sram_we_n) overlap = 1;
            if (n == 1) begin
                ce_s = sram_ce_n; ben_s = sram_be_n; adr_s = sram_adr; dqo_s = sram_dq_o;
                if (scramble) begin
                    adr = 27'($urandom); wdata = $urandom; byteen = 4'($urandom);
                    rwb = 1'($urandom); en = 1'($urandom);
                end
            end
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (!hold) en = 1'b0;
        check({tag, " latency"}, lat, W + 3);
        check({tag, " ce_n in setup"}, 32'(ce_s), 32'h0);
        check({tag, " be_n"}, 32'(ben_s), 32'(exp_ben));
        check({tag, " sram_adr"}, 32'(adr_s), 32'(a));
        check({tag, " oe_n low cycles"}, oe_low, exp_oe);
        check({tag, " we_n low cycles"}, we_low, exp_we);
        check({tag, " dq_oe cycles"}, dqoe_hi, rw ? 0 : W + 3);
        check({tag, " oe/we overlap"}, 32'(overlap), 32'h0);
        check({tag, " rdata"}, rdata, exp_rd);
        if (!rw) check({tag, " dq_o"}, dqo_s, wd);
        @(posedge ph1); @(negedge ph1);
        check({tag, " busy after done"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int          done_cnt, lat, oe_low, we_low, bad_adr;
        logic        rw;
        logic [26:0] a;
        logic [31:0] wd, exp_rd;
        logic [3:0]  be;

        tbl[0] = '{1'b0, 27'h4AD, 32'h21212121, 4'hF, 32'h00000000, 0, 3, 4'h0};
        tbl[1] = '{1'b1, 27'h4AD, 32'h00000000, 4'h0, 32'h21212121, 3, 0, 4'h0};
        tbl[2] = '{1'b0, 27'h0AD, 32'h11111111, 4'hF, 32'h21212121, 0, 3, 4'h0};
        tbl[3] = '{1'b0, 27'h0AD, 32'hDDCCBBAA, 4'h5, 32'h21212121, 0, 3, 4'hA};
        tbl[4] = '{1'b1, 27'h0AD, 32'hFFFFFFFF, 4'hF, 32'h11CC11AA, 3, 0, 4'h0};
        tbl[5] = '{1'b0, 27'h0AD, 32'h99999999, 4'h0, 32'h11CC11AA, 0, 0, 4'hF};
        tbl[6] = '{1'b1, 27'h0AD, 32'h00000000, 4'h0, 32'h11CC11AA, 3, 0, 4'h0};
        tbl[7] = '{1'b1, 27'h4AD, 32'h00000000, 4'h0, 32'h21212121, 3, 0, 4'h0};

        reset = 1'b0; en = 1'b0; rwb = 1'b1; adr = '0; wdata = '0; byteen = '0;
        w0_en = 1'b0; w0_rwb = 1'b1; w0_adr = '0; w0_wdata = '0; w0_byteen = '0;
        ref_rdata = '0;

        @(negedge ph1); @(negedge ph1);
        check("reset done", 32'(done), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset rdata", rdata, 32'h0);
        check("reset sram_adr", 32'(sram_adr), 32'h0);
        check("reset dq_o/dq_oe", {sram_dq_o[30:0], sram_dq_oe}, 32'h0);
        check("reset strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, 1'b0}, 32'hE);
        check("reset be_n", 32'(sram_be_n), 32'hF);
        #1 reset = 1'b1;
        @(negedge ph1);

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].rw, tbl[i].a, tbl[i].wd, tbl[i].be, 1'b0, 1'b0,
                  tbl[i].exp_rd, tbl[i].exp_oe, tbl[i].exp_we, tbl[i].exp_ben);
        end
        ref_rdata = 32'h21212121;

        // Read then write with en held; second SETUP must land two cycles after done
        do_op("b2b read", 1'b1, 27'h4AD, 32'h0, 4'h0, 1'b0, 1'b1,
              32'h21212121, W + 1, 0, 4'h0);
        do_op("b2b write", 1'b0, 27'h4AD, 32'h21212121, 4'hF, 1'b0, 1'b0,
              32'h21212121, 0, W + 1, 4'h0);

        // Reset in the middle of ACCESS abandons the access
        rwb = 1'b1; adr = 27'h4AD; byteen = 4'h0; en = 1'b1;
        @(posedge ph1); @(negedge ph1);
        @(posedge ph1); @(negedge ph1);
        check("rst pre oe_n", 32'(sram_oe_n), 32'h0);
        #1 reset = 1'b0; en = 1'b0;
        #1;
        check("rst strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        check("rst busy", 32'(busy), 32'h0);
        check("rst dq_oe", 32'(sram_dq_oe), 32'h0);
        #2 reset = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge ph1); @(negedge ph1);
            if (done) done_cnt++;
        end
        check("rst no done", done_cnt, 0);
        ref_rdata = 32'h0;
        check("rst rdata", rdata, ref_rdata);
        do_op("post-rst read", 1'b1, 27'h4AD, 32'h0, 4'h0, 1'b0, 1'b0,
              32'h21212121, W + 1, 0, 4'h0);
        ref_rdata = 32'h21212121;

        // Fill the random pool so every later read has a known value
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            a  = {15'($urandom), 12'(i)};
            ref_mem[i] = wd;
            do_op($sformatf("fill%0d", i), 1'b0, a, wd, 4'hF, 1'b0, 1'b0,
                  ref_rdata, 0, W + 1, 4'h0);
        end

        for (int k = 0; k < 150; k++) begin
            rw = 1'($urandom);
            a  = {15'($urandom), 12'($urandom_range(0, 15))};
            wd = $urandom;
            be = 4'($urandom);
            if (rw) ref_rdata = ref_mem[a[3:0]];
            else    ref_mem[a[3:0]] = merge(ref_mem[a[3:0]], wd, be);
            exp_rd = ref_rdata;
            do_op($sformatf("rnd%0d", k), rw, a, wd, be, 1'b1, 1'b0, exp_rd,
                  rw ? W + 1 : 0, (!rw && be != 4'h0) ? W + 1 : 0, rw ? 4'h0 : ~be);
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                @(posedge ph1); @(negedge ph1);
            end
        end

        // WAIT=0 instance: inputs altered during SETUP must not leak into the access
        w0_adr = 27'h123; w0_rwb = 1'b1; w0_byteen = 4'hF; w0_wdata = 32'h0; w0_en = 1'b1;
        lat = 0; oe_low = 0; we_low = 0; bad_adr = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge ph1); @(negedge ph1);
            if (!w0_sram_oe_n) oe_low++;
            if (!w0_sram_we_n) we_low++;
            if (w0_sram_dq_oe) we_low++;
            if (w0_sram_adr !== 27'h123) bad_adr++;
            if (n == 1) begin
                w0_adr = 27'h7FF; w0_rwb = 1'b0; w0_wdata = 32'hFFFFFFFF;
            end
            if (w0_done === 1'b1) begin
                lat = n;
                break;
            end
        end
        w0_en = 1'b0;
        check("w0 latency", lat, 3);
        check("w0 oe_n low cycles", oe_low, 1);
        check("w0 write activity", we_low, 0);
        check("w0 sram_adr held", bad_adr, 0);
        check("w0 rdata", w0_rdata, 32'h5A5A5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
